// File: rtl/dsram_arbiter.sv
// rtl/dsram_arbiter.sv - two-port arbiter for the shared data SRAM port
//
// Shares one single-cycle data SRAM between the execute stage (port 0,
// fixed priority) and a secondary master (port 1). Port 1 is forced through
// after STARVE_LIMIT consecutive denied cycles. Read data returns one cycle
// after the grant and is steered to the port that issued the read.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pN_req/wen/addr/wdata      request from port N (wen == 0 means read)
//   pN_gnt                     combinational grant to port N
//   pN_rvalid/pN_rdata         read response for port N (rdata zero when idle)
//   sram_en/wen/addr/wdata     SRAM command, all zero when nothing is granted
//   sram_rdata                 SRAM read data, one cycle after a read enable
//   starve_force               port 1 grant is being forced this cycle
module dsram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [3:0]  p0_wen,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic [3:0]  p1_wen,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        starve_force
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;
  logic       at_limit;

  assign at_limit = (starve_cnt_q == LIMIT);

  always_comb begin
    p0_gnt       = 1'b0;
    p1_gnt       = 1'b0;
    starve_force = p0_req && p1_req && at_limit;
    sram_en      = 1'b0;
    sram_wen     = 4'h0;
    sram_addr    = 32'h0;
    sram_wdata   = 32'h0;
    starve_cnt_d = 4'h0;
    rd_pend_d    = 1'b0;
    rd_owner_d   = 1'b0;

    // Port 0 wins contention unless port 1 has waited out its budget.
    if (p1_req && (!p0_req || at_limit)) begin
      p1_gnt = 1'b1;
    end else if (p0_req) begin
      p0_gnt = 1'b1;
    end

    if (p1_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = p1_wen;
      sram_addr  = p1_addr;
      sram_wdata = p1_wdata;
      rd_pend_d  = (p1_wen == 4'h0);
      rd_owner_d = 1'b1;
    end else if (p0_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = p0_wen;
      sram_addr  = p0_addr;
      sram_wdata = p0_wdata;
      rd_pend_d  = (p0_wen == 4'h0);
      rd_owner_d = 1'b0;
    end

    // Count only denied cycles of a live port 1 request; saturate at the limit.
    if (p1_req && !p1_gnt) begin
      starve_cnt_d = at_limit ? starve_cnt_q : starve_cnt_q + 4'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= 4'h0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign p0_rvalid = rd_pend_q && !rd_owner_q;
  assign p1_rvalid = rd_pend_q && rd_owner_q;
  assign p0_rdata  = p0_rvalid ? sram_rdata : 32'h0;
  assign p1_rdata  = p1_rvalid ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_dsram_arbiter.sv
// tb/tb_dsram_arbiter.sv - directed self-checking bench for dsram_arbiter
module tb_dsram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p1_req;
  logic [3:0]  p0_wen, p1_wen;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata = 32'h0;
  logic        starve_force;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:63];

  dsram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .starve_force(starve_force)
  );

  always #5 clk = ~clk;

  // Single-cycle SRAM: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen == 4'h0) begin
        sram_rdata <= mem[sram_addr[7:2]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (sram_wen[b]) mem[sram_addr[7:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive0(input logic req, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    p0_req = req; p0_wen = wen; p0_addr = addr; p0_wdata = wdata;
  endtask

  task automatic drive1(input logic req, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    p1_req = req; p1_wen = wen; p1_addr = addr; p1_wdata = wdata;
  endtask

  logic exp_p0 [0:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic exp_p1 [0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    mem[0] <= 32'h0000000A;
    mem[1] <= 32'h0000000B;
    mem[4] <= 32'hDEADBEEF;

    reset = 1'b1;
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b0, 4'h0, 32'h0, 32'h0);
    cyc();
    cyc();
    #1;
    check("rst_p0_rvalid", 32'(p0_rvalid), 32'h0);
    check("rst_p1_rvalid", 32'(p1_rvalid), 32'h0);
    check("rst_p0_rdata", p0_rdata, 32'h0);
    check("rst_p1_rdata", p1_rdata, 32'h0);
    check("rst_force", 32'(starve_force), 32'h0);
    reset = 1'b0;
    cyc();

    // Idle: SRAM command fully zero, no grants.
    #1;
    check("idle_en", 32'(sram_en), 32'h0);
    check("idle_wen", 32'(sram_wen), 32'h0);
    check("idle_addr", sram_addr, 32'h0);
    check("idle_wdata", sram_wdata, 32'h0);
    check("idle_gnt", {30'h0, p1_gnt, p0_gnt}, 32'h0);
    cyc();

    // Port 0 lone read of 0x10.
    drive0(1'b1, 4'h0, 32'h10, 32'h0);
    #1;
    check("rd0_gnt", 32'(p0_gnt), 32'h1);
    check("rd0_p1gnt", 32'(p1_gnt), 32'h0);
    check("rd0_sram_en", 32'(sram_en), 32'h1);
    check("rd0_sram_addr", sram_addr, 32'h10);
    cyc();
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("rd0_rvalid", 32'(p0_rvalid), 32'h1);
    check("rd0_rdata", p0_rdata, 32'hDEADBEEF);
    check("rd0_p1_rvalid", 32'(p1_rvalid), 32'h0);
    check("rd0_p1_rdata", p1_rdata, 32'h0);
    cyc();

    // Port 1 lone partial write, then read-back in the following cycle.
    drive1(1'b1, 4'h3, 32'h20, 32'h12345678);
    #1;
    check("wr1_gnt", 32'(p1_gnt), 32'h1);
    check("wr1_sram_wen", 32'(sram_wen), 32'h3);
    check("wr1_sram_wdata", sram_wdata, 32'h12345678);
    check("wr1_sram_addr", sram_addr, 32'h20);
    cyc();
    drive1(1'b1, 4'h0, 32'h20, 32'h0);
    #1;
    check("wr1_no_rvalid", {30'h0, p1_rvalid, p0_rvalid}, 32'h0);
    check("rb1_gnt", 32'(p1_gnt), 32'h1);
    cyc();
    drive1(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("rb1_rvalid", 32'(p1_rvalid), 32'h1);
    check("rb1_rdata", p1_rdata, 32'h00005678);
    cyc();

    // Continuous contention: port 1 forced on the fifth cycle.
    drive0(1'b1, 4'hF, 32'h30, 32'h1);
    drive1(1'b1, 4'hF, 32'h34, 32'h2);
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("starve_p0gnt_c%0d", c), 32'(p0_gnt), 32'(exp_p0[c]));
      check($sformatf("starve_p1gnt_c%0d", c), 32'(p1_gnt), 32'(exp_p1[c]));
      check($sformatf("starve_force_c%0d", c), 32'(starve_force), 32'(exp_p1[c]));
      cyc();
    end
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b0, 4'h0, 32'h0, 32'h0);
    cyc();

    // Alternating reads: p0@0x0 then p1@0x4.
    drive0(1'b1, 4'h0, 32'h0, 32'h0);
    #1;
    check("alt_p0gnt", 32'(p0_gnt), 32'h1);
    cyc();
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b1, 4'h0, 32'h4, 32'h0);
    #1;
    check("alt_p1gnt", 32'(p1_gnt), 32'h1);
    check("alt_t1_p0_rvalid", 32'(p0_rvalid), 32'h1);
    check("alt_t1_p0_rdata", p0_rdata, 32'hA);
    check("alt_t1_p1_rvalid", 32'(p1_rvalid), 32'h0);
    cyc();
    drive1(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("alt_t2_p1_rvalid", 32'(p1_rvalid), 32'h1);
    check("alt_t2_p1_rdata", p1_rdata, 32'hB);
    check("alt_t2_p0_rvalid", 32'(p0_rvalid), 32'h0);
    check("alt_t2_p0_rdata", p0_rdata, 32'h0);
    cyc();

    // Build up starvation, then a read granted while reset is asserted.
    drive0(1'b1, 4'hF, 32'h30, 32'h1);
    drive1(1'b1, 4'hF, 32'h34, 32'h2);
    cyc();
    cyc();
    reset = 1'b1;
    drive0(1'b1, 4'h0, 32'h10, 32'h0);
    #1;
    check("rst_rd_gnt", 32'(p0_gnt), 32'h1);
    cyc();
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("rst_rd_t1_rvalid", {30'h0, p1_rvalid, p0_rvalid}, 32'h0);
    cyc();
    reset = 1'b0;
    drive0(1'b1, 4'hF, 32'h30, 32'h1);
    drive1(1'b1, 4'hF, 32'h34, 32'h2);
    #1;
    check("rst_rd_t2_rvalid", {30'h0, p1_rvalid, p0_rvalid}, 32'h0);
    // Counter restarted from zero: four denied cycles before the force.
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("post_rst_force_c%0d", c), 32'(starve_force), (c == 4) ? 32'h1 : 32'h0);
      cyc();
    end
    drive0(1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b0, 4'h0, 32'h0, 32'h0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
